// File: rtl/true_dp_ram.sv
// 16 x 8 true dual-port synchronous RAM with tri-state data buses, one clock domain.
// Port 0 wins a same-address write/write collision. Reads return the old contents when a write hits the same address.
module true_dp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re_0,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    inout  wire  [DATA_WIDTH-1:0] data_0,
    input  logic                  re_1,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    inout  wire  [DATA_WIDTH-1:0] data_1
);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_READ,
        MODE_WRITE
    } mode_e;

    function automatic mode_e decode_mode(input logic re, input logic we);
        case ({re, we})
            2'b10:   return MODE_READ;
            2'b01:   return MODE_WRITE;
            default: return MODE_IDLE;
        endcase
    endfunction

    mode_e mode_0;
    mode_e mode_1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_0_q;
    logic [DATA_WIDTH-1:0] rd_0_d;
    logic [DATA_WIDTH-1:0] rd_1_q;
    logic [DATA_WIDTH-1:0] rd_1_d;
    logic                  wr_0_en;
    logic                  wr_1_en;

    assign mode_0 = decode_mode(re_0, we_0);
    assign mode_1 = decode_mode(re_1, we_1);

    assign wr_0_en = (mode_0 == MODE_WRITE);
    // Port 1 yields to port 0 when both write the same word.
    assign wr_1_en = (mode_1 == MODE_WRITE) && !(wr_0_en && (addr_0 == addr_1));

    // NOTE: every variable written here gets a default first, so a port that is not reading keeps its register and no latch is inferred.
    always_comb begin
        rd_0_d = rd_0_q;
        rd_1_d = rd_1_q;
        if (mode_0 == MODE_READ) rd_0_d = mem_q[addr_0];
        if (mode_1 == MODE_READ) rd_1_d = mem_q[addr_1];
    end

    // NOTE: non-blocking updates mean the read registers sample mem_q before this edge's writes land, which gives read-before-write for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is cleared on reset because the buffer must read back zero afterwards; this rules out a plain block-RAM mapping.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_0_q <= '0;
            rd_1_q <= '0;
        end else begin
            rd_0_q <= rd_0_d;
            rd_1_q <= rd_1_d;
            if (wr_0_en) mem_q[addr_0] <= data_0;
            if (wr_1_en) mem_q[addr_1] <= data_1;
        end
    end

    assign data_0 = (!rst && mode_0 == MODE_READ) ? rd_0_q : 'z;
    assign data_1 = (!rst && mode_1 == MODE_READ) ? rd_1_q : 'z;

endmodule

// File: tb/tb_true_dp_ram.sv
// Self-checking bench for true_dp_ram: directed scenarios plus random traffic against an array model.
// Buses are pulled up, so a released bus reads all ones.
module tb_true_dp_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] BUS_Z = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          re_0, we_0, re_1, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] drv_0, drv_1;
    logic          drv_en_0, drv_en_1;
    wire  [DW-1:0] data_0;
    wire  [DW-1:0] data_1;

    always #5 clk = ~clk;

    assign data_0 = drv_en_0 ? drv_0 : 'z;
    assign data_1 = drv_en_1 ? drv_1 : 'z;

    for (genvar b = 0; b < DW; b++) begin : g_pull
        pullup (data_0[b]);
        pullup (data_1[b]);
    end

    true_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .re_0   (re_0),
        .we_0   (we_0),
        .addr_0 (addr_0),
        .data_0 (data_0),
        .re_1   (re_1),
        .we_1   (we_1),
        .addr_1 (addr_1),
        .data_1 (data_1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rd  [2];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic re, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            re_0 = re; we_0 = we; addr_0 = a; drv_0 = d; drv_en_0 = we;
        end else begin
            re_1 = re; we_1 = we; addr_1 = a; drv_1 = d; drv_en_1 = we;
        end
    endtask

    task automatic idle_both();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
    endtask

    // Reference: one rising edge of the RAM, straight from the behavioural rules.
    task automatic model_edge();
        logic [DW-1:0] old_mem [DEPTH];
        logic          rd0, rd1, wr0, wr1;
        if (rst) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            ref_rd[0] = '0;
            ref_rd[1] = '0;
            return;
        end
        old_mem = ref_mem;
        rd0 = re_0 && !we_0;
        rd1 = re_1 && !we_1;
        wr0 = we_0 && !re_0;
        wr1 = we_1 && !re_1;
        if (rd0) ref_rd[0] = old_mem[addr_0];
        if (rd1) ref_rd[1] = old_mem[addr_1];
        if (wr1 && !(wr0 && addr_0 == addr_1)) ref_mem[addr_1] = drv_1;
        if (wr0) ref_mem[addr_0] = drv_0;
    endtask

    task automatic check_bus(input string tag);
        if (!drv_en_0)
            check($sformatf("%s/bus0", tag), data_0,
                  (!rst && re_0 && !we_0) ? ref_rd[0] : BUS_Z);
        if (!drv_en_1)
            check($sformatf("%s/bus1", tag), data_1,
                  (!rst && re_1 && !we_1) ? ref_rd[1] : BUS_Z);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_bus(tag);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            set_port(0, 1'b1, 1'b0, AW'(a), '0);
            set_port(1, 1'b1, 1'b0, AW'(DEPTH - 1 - a), '0);
            cycle($sformatf("%s_a%0d", tag, a));
        end
        idle_both();
    endtask

    initial begin
        rst = 1'b1;
        idle_both();
        foreach (ref_mem[i]) ref_mem[i] = 'x;
        ref_rd[0] = 'x;
        ref_rd[1] = 'x;
        #1;
        check_bus("rst_comb");
        cycle("rst0");
        cycle("rst1");
        rst = 1'b0;

        read_all("post_rst");

        // Port 0 fills the low half, port 1 the high half.
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1'b0, 1'b1, AW'(i),     (i == 3) ? 8'hA5 : DW'($urandom));
            set_port(1, 1'b0, 1'b1, AW'(8 + i), (i == 4) ? 8'h3C : DW'($urandom));
            cycle($sformatf("fill%0d", i));
        end
        idle_both();
        cycle("fill_idle");
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1'b1, 1'b0, AW'(i), '0);
            set_port(1, 1'b1, 1'b0, AW'(8 + i), '0);
            cycle($sformatf("rdback%0d", i));
        end
        idle_both();
        cycle("rdback_idle");
        check("addr3_value", ref_mem[3], 8'hA5);

        // Cross-port visibility.
        set_port(0, 1'b0, 1'b1, 4'd9, 8'h5A);
        cycle("x_wr9");
        idle_both();
        set_port(1, 1'b1, 1'b0, 4'd9, '0);
        cycle("x_rd9");
        check("x_rd9_lit", data_1, 8'h5A);
        idle_both();
        set_port(1, 1'b0, 1'b1, 4'd2, 8'hC3);
        cycle("x_wr2");
        idle_both();
        set_port(0, 1'b1, 1'b0, 4'd2, '0);
        cycle("x_rd2");
        check("x_rd2_lit", data_0, 8'hC3);

        // Write/write collision: port 0 wins.
        set_port(0, 1'b0, 1'b1, 4'd4, 8'h11);
        set_port(1, 1'b0, 1'b1, 4'd4, 8'h22);
        cycle("ww4");
        set_port(0, 1'b1, 1'b0, 4'd4, '0);
        set_port(1, 1'b1, 1'b0, 4'd4, '0);
        cycle("ww4_rd");
        check("ww4_lit", data_1, 8'h11);

        // Read/write collision: read-before-write.
        idle_both();
        set_port(0, 1'b0, 1'b1, 4'd6, 8'h00);
        cycle("rw6_pre");
        set_port(0, 1'b0, 1'b1, 4'd6, 8'hEE);
        set_port(1, 1'b1, 1'b0, 4'd6, '0);
        cycle("rw6");
        check("rw6_old_lit", data_1, 8'h00);
        idle_both();
        set_port(1, 1'b1, 1'b0, 4'd6, '0);
        cycle("rw6_re");
        check("rw6_new_lit", data_1, 8'hEE);

        // re=we=1 is idle: no write, no drive. Then a plain idle cycle.
        idle_both();
        set_port(0, 1'b0, 1'b1, 4'd5, 8'h5C);
        cycle("both_pre");
        set_port(0, 1'b1, 1'b1, 4'd5, 8'hFF);
        set_port(1, 1'b1, 1'b1, 4'd5, 8'hFF);
        cycle("both_en");
        idle_both();
        cycle("idle");
        set_port(0, 1'b1, 1'b0, 4'd5, '0);
        cycle("both_rd");
        check("both_lit", data_0, 8'h5C);

        // Random traffic on both ports.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                int m;
                m = $urandom_range(0, 3);
                set_port(p, m[0], m[1], AW'($urandom), DW'($urandom));
            end
            cycle($sformatf("rnd%0d", n));
        end

        // Reset in the middle of a read burst, with a write pending on port 1.
        idle_both();
        for (int a = 0; a < 4; a++) begin
            set_port(0, 1'b1, 1'b0, AW'(a), '0);
            cycle($sformatf("burst%0d", a));
        end
        set_port(1, 1'b0, 1'b1, 4'd3, 8'hAA);
        rst = 1'b1;
        #1;
        check("mid_rst_bus0", data_0, BUS_Z);
        cycle("mid_rst");
        rst = 1'b0;
        idle_both();
        read_all("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
